// File: rtl/stopwatch_display_if.sv
// rtl/stopwatch_display_if.sv - stopwatch fields, lap pulse and 7-segment display bundle
interface stopwatch_display_if;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [6:0] m_sec;
  logic       lap;
  logic [6:0] hex7;
  logic [6:0] hex6;
  logic [6:0] hex5;
  logic [6:0] hex4;
  logic [6:0] hex3;
  logic [6:0] hex2;
  logic [6:0] hex1;
  logic [6:0] hex0;
  logic       lap_active;
  logic       busy;

  modport master (
    output hour, minute, second, m_sec, lap,
    input  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0, lap_active, busy
  );

  modport slave (
    input  hour, minute, second, m_sec, lap,
    output hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0, lap_active, busy
  );
endinterface

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - sampled HH MM SS CC to eight 7-segment digits with lap hold
// Optional LEADING_ZERO_BLANK_EN blanks hex7 when the hour tens digit is zero.
module stopwatch_display #(
  parameter int REFRESH_DIV    = 500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  stopwatch_display_if.slave bus
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam logic [6:0] BLANK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] GLYPH0 = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX7_RST = BLANK;
`else
  localparam logic [6:0] HEX7_RST = GLYPH0;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, CONVERT, LOAD} state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [24:0]       snap_q, snap_d;
  logic [2:0]        it_q, it_d;
  logic [3:0][6:0]   bin_q, bin_d;
  logic [3:0][7:0]   bcd_q, bcd_d;
  logic [7:0][6:0]   hex_q, hex_d;
  logic              lap_active_q, lap_active_d;
  logic              busy_q, busy_d;

  logic [24:0] live;
  logic        tick;
  logic        match;

  assign live  = {bus.hour, bus.minute, bus.second, bus.m_sec};
  assign tick  = (rc_q == RC_W'(REFRESH_DIV - 1));
  assign match = (live == snap_q);

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // One shift-add-3 step: adjust BCD nibbles, then shift {bcd, bin} left by one.
  function automatic logic [14:0] dabble(input logic [7:0] bcd, input logic [6:0] bin);
    logic [7:0] b;
    b = bcd;
    if (b[3:0] >= 4'd5) b[3:0] = b[3:0] + 4'd3;
    if (b[7:4] >= 4'd5) b[7:4] = b[7:4] + 4'd3;
    return {b[6:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~g : g;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = CHECK;
      CHECK:   if (match) state_d = CONVERT;
      CONVERT: if (it_q == 3'd6) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rc_d   = tick ? '0 : rc_q + RC_W'(1);
    snap_d = snap_q;
    if ((state_q == IDLE && tick) || (state_q == CHECK && !match)) snap_d = live;

    it_d  = (state_q == CONVERT) ? it_q + 3'd1 : 3'd0;
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (state_q == CHECK && match) begin
      bin_d[3] = sat99({1'b0, snap_q[24:19]});
      bin_d[2] = sat99({1'b0, snap_q[18:13]});
      bin_d[1] = sat99({1'b0, snap_q[12:7]});
      bin_d[0] = sat99(snap_q[6:0]);
      bcd_d    = '0;
    end else if (state_q == CONVERT) begin
      for (int f = 0; f < 4; f++) {bcd_d[f], bin_d[f]} = dabble(bcd_q[f], bin_q[f]);
    end

    // The lap toggle resolved this cycle decides whether LOAD may update.
    lap_active_d = lap_active_q ^ bus.lap;
    busy_d       = (state_d != IDLE);

    hex_d = hex_q;
    if (state_q == LOAD && !lap_active_d) begin
      hex_d[7] = seg(bcd_q[3][7:4]);
      hex_d[6] = seg(bcd_q[3][3:0]);
      hex_d[5] = seg(bcd_q[2][7:4]);
      hex_d[4] = seg(bcd_q[2][3:0]);
      hex_d[3] = seg(bcd_q[1][7:4]);
      hex_d[2] = seg(bcd_q[1][3:0]);
      hex_d[1] = seg(bcd_q[0][7:4]);
      hex_d[0] = seg(bcd_q[0][3:0]);
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_q[3][7:4] == 4'd0) hex_d[7] = BLANK;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rc_q         <= '0;
      snap_q       <= '0;
      it_q         <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      lap_active_q <= 1'b0;
      busy_q       <= 1'b0;
      hex_q        <= {HEX7_RST, {7{GLYPH0}}};
    end else begin
      rc_q         <= rc_d;
      snap_q       <= snap_d;
      it_q         <= it_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      lap_active_q <= lap_active_d;
      busy_q       <= busy_d;
      hex_q        <= hex_d;
    end
  end

  assign bus.hex7       = hex_q[7];
  assign bus.hex6       = hex_q[6];
  assign bus.hex5       = hex_q[5];
  assign bus.hex4       = hex_q[4];
  assign bus.hex3       = hex_q[3];
  assign bus.hex2       = hex_q[2];
  assign bus.hex1       = hex_q[1];
  assign bus.hex0       = hex_q[0];
  assign bus.lap_active = lap_active_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - randomized self-checking bench for stopwatch_display
module tb_stopwatch_display;
  localparam int DIV = 16;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   n_edge;
  logic [55:0] shown;

  stopwatch_display_if bus();

  stopwatch_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Edges seen since reset; a refresh tick lands on every DIV-th edge.
  always @(posedge clock or posedge reset) begin
    if (reset) n_edge <= 0;
    else       n_edge <= n_edge + 1;
  end

  wire [55:0] disp = {bus.hex7, bus.hex6, bus.hex5, bus.hex4,
                      bus.hex3, bus.hex2, bus.hex1, bus.hex0};

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return ~tbl[d];
  endfunction

  function automatic logic [55:0] expect_disp(input int h, input int m, input int s, input int c);
    int v [4];
    int x;
    logic [55:0] r;
    v[0] = h; v[1] = m; v[2] = s; v[3] = c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = (v[i] > 99) ? 99 : v[i];
      r[55-14*i -: 7] = glyph(x / 10);
      r[48-14*i -: 7] = glyph(x % 10);
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (h < 10) r[55:49] = 7'h7F;
`endif
    return r;
  endfunction

  function automatic logic [55:0] reset_disp();
    logic [55:0] r;
    r = {8{7'h40}};
`ifdef LEADING_ZERO_BLANK_EN
    r[55:49] = 7'h7F;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s, input int c);
    bus.hour   = 6'(h);
    bus.minute = 6'(m);
    bus.second = 6'(s);
    bus.m_sec  = 7'(c);
  endtask

  task automatic goto_tick();
    do step(); while (n_edge % DIV != 0);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 30) begin
      cnt++;
      step();
    end
  endtask

  task automatic pulse_lap();
    bus.lap = 1'b1;
    step();
    bus.lap = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.lap = 1'b0;
    set_time(0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    total++; if (disp !== reset_disp()) begin bad++; $display("FAIL reset_disp got=%h want=%h", disp, reset_disp()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.lap_active !== 1'b0) begin bad++; $display("FAIL reset_lap got=%b want=0", bus.lap_active); end
    @(negedge clock) reset = 1'b0;
    shown = reset_disp();
  endtask

  task automatic test_basic();
    int cnt;
    set_time(12, 34, 56, 78);
    goto_tick();
    count_busy(cnt);
    total++; if (cnt !== 9) begin bad++; $display("FAIL basic_busy got=%0d want=9", cnt); end
    shown = expect_disp(12, 34, 56, 78);
    total++; if (disp !== shown) begin bad++; $display("FAIL basic_disp got=%h want=%h", disp, shown); end
  endtask

  task automatic test_check_retry();
    int cnt;
    goto_tick();
    bus.m_sec = 7'd79;
    count_busy(cnt);
    total++; if (cnt !== 10) begin bad++; $display("FAIL retry_busy got=%0d want=10", cnt); end
    shown = expect_disp(12, 34, 56, 79);
    total++; if (disp !== shown) begin bad++; $display("FAIL retry_disp got=%h want=%h", disp, shown); end
  endtask

  task automatic test_saturate();
    int cnt;
    set_time(12, 34, 60, 100);
    goto_tick();
    count_busy(cnt);
    total++; if (cnt !== 9) begin bad++; $display("FAIL sat_busy got=%0d want=9", cnt); end
    shown = expect_disp(12, 34, 60, 100);
    total++; if (disp !== shown) begin bad++; $display("FAIL sat_disp got=%h want=%h", disp, shown); end
  endtask

  task automatic test_lap();
    int cnt;
    set_time(0, 0, 1, 0);
    goto_tick();
    count_busy(cnt);
    shown = expect_disp(0, 0, 1, 0);
    total++; if (disp !== shown) begin bad++; $display("FAIL lap_start got=%h want=%h", disp, shown); end
    pulse_lap();
    total++; if (bus.lap_active !== 1'b1) begin bad++; $display("FAIL lap_set got=%b want=1", bus.lap_active); end
    for (int s = 2; s <= 5; s++) begin
      set_time(0, 0, s, 0);
      goto_tick();
      count_busy(cnt);
      total++; if (disp !== shown) begin bad++; $display("FAIL lap_hold s=%0d got=%h want=%h", s, disp, shown); end
      total++; if (bus.lap_active !== 1'b1) begin bad++; $display("FAIL lap_hold_flag got=%b want=1", bus.lap_active); end
    end
    pulse_lap();
    total++; if (bus.lap_active !== 1'b0) begin bad++; $display("FAIL lap_clear got=%b want=0", bus.lap_active); end
    goto_tick();
    count_busy(cnt);
    shown = expect_disp(0, 0, 5, 0);
    total++; if (disp !== shown) begin bad++; $display("FAIL lap_release got=%h want=%h", disp, shown); end
  endtask

  task automatic test_lap_on_load();
    set_time(0, 0, 7, 0);
    goto_tick();
    repeat (8) step();
    pulse_lap();
    total++; if (bus.lap_active !== 1'b1) begin bad++; $display("FAIL lapload_set got=%b want=1", bus.lap_active); end
    total++; if (disp !== shown) begin bad++; $display("FAIL lapload_hold got=%h want=%h", disp, shown); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL lapload_busy got=%b want=0", bus.busy); end
    goto_tick();
    repeat (8) step();
    pulse_lap();
    shown = expect_disp(0, 0, 7, 0);
    total++; if (bus.lap_active !== 1'b0) begin bad++; $display("FAIL lapload_clr got=%b want=0", bus.lap_active); end
    total++; if (disp !== shown) begin bad++; $display("FAIL lapload_upd got=%h want=%h", disp, shown); end
  endtask

  task automatic test_reset_mid_convert();
    int cnt;
    set_time(0, 0, 9, 42);
    goto_tick();
    repeat (4) step();
    reset = 1'b1;
    #1;
    total++; if (disp !== reset_disp()) begin bad++; $display("FAIL midrst_disp got=%h want=%h", disp, reset_disp()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    @(negedge clock) reset = 1'b0;
    goto_tick();
    count_busy(cnt);
    total++; if (cnt !== 9) begin bad++; $display("FAIL midrst_busy2 got=%0d want=9", cnt); end
    shown = expect_disp(0, 0, 9, 42);
    total++; if (disp !== shown) begin bad++; $display("FAIL midrst_conv got=%h want=%h", disp, shown); end
  endtask

  task automatic test_random();
    int h, m, s, c, chg, cnt;
    for (int it = 0; it < 12; it++) begin
      h = $urandom_range(0, 63);
      m = $urandom_range(0, 63);
      s = $urandom_range(0, 63);
      c = $urandom_range(0, 127);
      set_time(h, m, s, c);
      goto_tick();
      chg = $urandom_range(0, 1);
      if (chg == 1) begin
        c = (c + 1 + $urandom_range(0, 100)) % 128;
        bus.m_sec = 7'(c);
      end
      count_busy(cnt);
      total++; if (cnt !== 9 + chg) begin bad++; $display("FAIL rand_busy it=%0d got=%0d want=%0d", it, cnt, 9 + chg); end
      shown = expect_disp(h, m, s, c);
      total++; if (disp !== shown) begin bad++; $display("FAIL rand_disp it=%0d got=%h want=%h", it, disp, shown); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_check_retry();
    test_saturate();
    test_lap();
    test_lap_on_load();
    test_reset_mid_convert();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Display stage directly downstream of the stopwatch counter block. It samples the binary `hour`/`minute`/`second`/`m_sec` fields at a fixed refresh rate and rejects samples taken while the counters are changing. It converts each field to two BCD digits with a multi-cycle shift-add-3 engine and drives eight 7-segment digits as HH MM SS CC. A lap input freezes the shown value while counting continues upstream.

## Interface
- `REFRESH_DIV`, 500000: clock cycles per refresh (100 Hz at 50 MHz); legal range ≥ 16.
- `SEG_ACTIVE_LOW`, 1: 1 = segment lit when bit is 0; 0 = lit when bit is 1.

- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `hour` in 6: binary hours from the stopwatch.
- `minute` in 6: binary minutes.
- `second` in 6: binary seconds.
- `m_sec` in 7: binary hundredths.
- `lap` in 1: one-cycle synchronous pulse from the debounced button; toggles lap hold.
- `hex7`..`hex0` out 7 each: segment vectors, bit0 = a … bit6 = g; `hex7` = hour tens, `hex0` = hundredths units.
- `lap_active` out 1: 1 while the display is frozen.
- `busy` out 1: 1 in any state other than IDLE.

## Operation
- Refresh counter `rc` runs 0..REFRESH_DIV−1 and wraps. The tick is `rc == REFRESH_DIV−1`.
- FSM states: IDLE, CHECK, CONVERT, LOAD.
- IDLE:
  - On a tick, capture all four inputs into `snap` and go to CHECK.
  - A tick arriving in any other state is ignored.
- CHECK:
  - If the live inputs equal `snap` in all four fields, go to CONVERT.
  - Otherwise recapture `snap` and stay in CHECK. There is no timeout.
- CONVERT:
  - Saturate each field to 99 first (values ≥ 100, e.g. transient `m_sec` = 100, become 99). Zero-extend to 7 bits.
  - Run 7 iterations of double-dabble, one per cycle, on all four fields in parallel. Each yields an 8-bit BCD pair.
  - After iteration 7, go to LOAD.
- LOAD:
  - If `lap_active` is 0 after this cycle's lap update, register the 8 encoded digits into `hex7..hex0`. Otherwise keep the outputs unchanged.
  - Return to IDLE.
- Digit encoding: standard 0–9 glyphs. Blank = all segments off. Polarity is set by SEG_ACTIVE_LOW.
- Lap handling:
  - A `lap` pulse toggles `lap_active` in any state.
  - If a pulse coincides with LOAD and sets `lap_active` to 1, that LOAD does not update the display.
  - If it clears `lap_active` in LOAD, the LOAD updates the display.
- Asynchronous reset, including mid-CONVERT:
  - FSM → IDLE, `rc` = 0, `snap` = 0, BCD work registers = 0.
  - `lap_active` = 0, `busy` = 0.
  - All `hex*` show glyph 0 (7'b1000000 when active-low).

## Timing
- Edge E0: tick edge, `snap` captured.
- Edge E1: CHECK passes.
- Edges E2..E8: conversion iterations.
- Edge E9: LOAD; new `hex*` values are visible after E9.
- Minimum latency is therefore 9 cycles from the tick edge to updated outputs. Each failed CHECK adds one cycle.
- `busy` is 1 from after E0 until after E9.
- `lap_active` changes on the edge that samples `lap` = 1. Outputs are fully registered.
- `rc` keeps counting in all states, so the refresh period is exact and independent of CHECK retries.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: `hex7` is blanked when the hour tens digit is 0. The reset value of `hex7` is also blank.
  - Undefined: `hex7` shows glyph 0. All digits are always displayed.

## Test plan
- Reset, REFRESH_DIV = 16, inputs 12:34:56.78 held → after the first tick plus 9 cycles, hex7..hex0 = 1,2,3,4,5,6,7,8 glyphs; `busy` high for exactly 9 cycles.
- Change `m_sec` 78 → 79 on the cycle after the snap edge → CHECK fails once, `snap` = 79, display shows …7,9 at tick + 10 cycles.
- `m_sec` = 100, `second` = 60 held → hex1,hex0 = 9,9 and hex3,hex2 = 6,0.
- Pulse `lap` while showing 00:00:01.00, then advance inputs to 00:00:05.00 over several refreshes → display stays 00000100 and `lap_active` = 1. Second `lap` pulse → the next LOAD shows 00000500.
- `lap` pulse coincident with the LOAD cycle → that update is suppressed and `lap_active` = 1.
- Assert `reset` mid-CONVERT → all `hex*` = glyph 0 immediately (hex7 blank with LEADING_ZERO_BLANK_EN), `busy` = 0; the next tick converts normally.
